// File: rtl/fxp_lane_converter.sv
// Multi-lane signed fixed-point format converter: rounding/saturation (or widening) in stage 1,
// output register in stage 2, a single global stall enable, and a sticky saturated-lane counter.
module fxp_lane_converter #(
    parameter int NUM_LANES      = 4,
    parameter int from_width     = 26,
    parameter int from_sign_bits = 2,
    parameter int from_int_bits  = 8,
    parameter int width          = 12,
    parameter int sign_bits      = 1,
    parameter int int_bits       = 3,
    parameter int SAT_CNT_W      = 16
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [1:0]                      round_mode,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_LANES*from_width-1:0] in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_LANES*width-1:0]      out_data,
    output logic [NUM_LANES-1:0]            out_sat,
    input  logic                            sat_clr,
    output logic [SAT_CNT_W-1:0]            sat_count
);

    localparam int from_frac_bits = from_width - from_sign_bits - from_int_bits;
    localparam int frac_bits      = width - sign_bits - int_bits;
    localparam int d_shift        = from_frac_bits - frac_bits;
    localparam int pad_w          = (d_shift < 0) ? -d_shift : 0;
    localparam int w_a            = from_width + pad_w + 1;
    localparam int w_b            = int_bits + frac_bits + 2;
    // Working width covers the zero-padded input, the +1 rounding carry and both saturation limits.
    localparam int w_r            = ((w_a > w_b) ? w_a : w_b) + 1;
    localparam int pop_w          = $clog2(NUM_LANES + 1);

    localparam logic signed [w_r-1:0] pos_lim = (w_r'(1) << (int_bits + frac_bits)) - w_r'(1);
    localparam logic signed [w_r-1:0] neg_lim = ~pos_lim;
    localparam logic [width-1:0] max_pos = {{sign_bits{1'b0}}, {(width - sign_bits){1'b1}}};
    localparam logic [width-1:0] max_neg = ~max_pos;

    logic                          en;
    logic [NUM_LANES*width-1:0]    conv_data;
    logic [NUM_LANES-1:0]          conv_sat;
    logic                          s1_valid;
    logic [NUM_LANES*width-1:0]    s1_data;
    logic [NUM_LANES-1:0]          s1_sat;
    logic [pop_w-1:0]              pop;
    logic [SAT_CNT_W:0]            sat_sum;

    // Handshake: a beat moves on a rising edge when valid && ready; both pipeline stages advance
    // together only when the output register is empty or being drained (no bubble collapsing).
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic signed [from_width-1:0]     lane_in;
        logic signed [w_r-1:0]            ext;
        logic signed [w_r-1:0]            r;
        logic [from_sign_bits-1:0]        top;
        logic                             exc;
        logic [width-1:0]                 lane_data;
        logic                             lane_sat;

        assign lane_in = in_data[i*from_width +: from_width];
        assign ext     = {{(w_r - from_width){lane_in[from_width-1]}}, lane_in};
        assign top     = lane_in[from_width-1 -: from_sign_bits];
        assign exc     = (top != '0) && (top != '1);

        if (d_shift > 0) begin : g_narrow
            localparam logic [w_r-1:0] s_mask = (w_r'(1) << (d_shift - 1)) - w_r'(1);
            logic signed [w_r-1:0] x;
            logic                  g;
            logic                  s;
            logic                  inc;

            assign x = ext >>> d_shift;
            assign g = ext[d_shift-1];
            assign s = |(ext & s_mask);

            always_comb begin
                inc = 1'b0;
                case (round_mode)
                    2'd1:    inc = g;
                    2'd2:    inc = g & (s | x[0]);
                    default: inc = 1'b0;
                endcase
            end

            assign r = x + w_r'(inc);
        end else begin : g_widen
            assign r = ext <<< pad_w;
        end

        always_comb begin
            lane_data = r[width-1:0];
            lane_sat  = 1'b0;
            if (exc) begin
                lane_data = max_pos;
                lane_sat  = 1'b1;
            end else if (r > pos_lim) begin
                lane_data = max_pos;
                lane_sat  = 1'b1;
            end else if (r < neg_lim) begin
                lane_data = max_neg;
                lane_sat  = 1'b1;
            end
        end

        assign conv_data[i*width +: width] = lane_data;
        assign conv_sat[i]                 = lane_sat;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_sat    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= '0;
        end else if (en) begin
            s1_valid  <= in_valid;
            out_valid <= s1_valid;
            if (in_valid) begin
                s1_data <= conv_data;
                s1_sat  <= conv_sat;
            end
            if (s1_valid) begin
                out_data <= s1_data;
                out_sat  <= s1_sat;
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            pop = pop + pop_w'(out_sat[i]);
        end
        sat_sum = {1'b0, sat_count} + (SAT_CNT_W + 1)'(pop);
    end

    // Clear wins over a coincident delivery; otherwise the count sticks at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sat_count <= '0;
        end else if (sat_clr) begin
            sat_count <= '0;
        end else if (out_valid && out_ready) begin
            sat_count <= sat_sum[SAT_CNT_W] ? '1 : sat_sum[SAT_CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_fxp_lane_converter.sv
// Directed bench for fxp_lane_converter (Q2.8.16 in, Q1.3.8 out): vector table plus
// hand-written stall, sat-counter clear/clamp and async-reset sequences.
module tb_fxp_lane_converter;

    localparam int NL = 4;
    localparam int FW = 26;
    localparam int W  = 12;
    localparam int CW = 16;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [1:0]        round_mode = 2'd0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [NL*FW-1:0]  in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [NL*W-1:0]   out_data;
    logic [NL-1:0]     out_sat;
    logic              sat_clr = 1'b0;
    logic [CW-1:0]     sat_count;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [1:0]       mode;
        logic [NL*FW-1:0] din;
        logic [NL*W-1:0]  dout;
        logic [NL-1:0]    sat;
    } vec_t;

    vec_t vecs[8];

    fxp_lane_converter dut (
        .clk(clk), .reset_n(reset_n), .round_mode(round_mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sat(out_sat), .sat_clr(sat_clr), .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] m, input int i0, input int i1, input int i2,
                                input int i3, input logic [11:0] o0, input logic [11:0] o1,
                                input logic [11:0] o2, input logic [11:0] o3, input logic [3:0] s);
        vec_t v;
        v.mode = m;
        v.din  = {FW'(i3), FW'(i2), FW'(i1), FW'(i0)};
        v.dout = {o3, o2, o1, o0};
        v.sat  = s;
        return v;
    endfunction

    function automatic logic [NL*FW-1:0] all_lanes(input int val);
        logic [NL*FW-1:0] d;
        for (int l = 0; l < NL; l++) d[l*FW +: FW] = FW'(val);
        return d;
    endfunction

    // One beat with out_ready high: absent at t and t+1, present at t+2, gone at t+3.
    task automatic run_vec(input int idx);
        @(negedge clk);
        in_valid   = 1'b1;
        in_data    = vecs[idx].din;
        round_mode = vecs[idx].mode;
        out_ready  = 1'b1;
        #1 check($sformatf("v%0d_in_ready", idx), in_ready, 1);
        @(negedge clk);
        in_valid   = 1'b0;
        in_data    = '0;
        round_mode = ~vecs[idx].mode;
        check($sformatf("v%0d_lat_t1", idx), out_valid, 0);
        @(negedge clk);
        check($sformatf("v%0d_valid", idx), out_valid, 1);
        check($sformatf("v%0d_data", idx), out_data, vecs[idx].dout);
        check($sformatf("v%0d_sat", idx), out_sat, vecs[idx].sat);
        @(negedge clk);
        check($sformatf("v%0d_no_dup", idx), out_valid, 0);
    endtask

    task automatic stream_beats(input int n, input logic [NL*FW-1:0] d);
        @(negedge clk);
        out_ready  = 1'b1;
        round_mode = 2'd0;
        in_valid   = 1'b1;
        in_data    = d;
        repeat (n) @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic stall_stream();
        logic [NL*W-1:0]  exp_q[$];
        logic [NL*W-1:0]  held;
        logic [NL*W-1:0]  e;
        logic [NL*FW-1:0] d;
        logic             stalled;
        int sent;
        int got;
        int cyc;
        sent = 0; got = 0; cyc = 0; stalled = 1'b0; held = '0;
        round_mode = 2'd0;
        while (got < 8 && cyc < 60) begin
            @(negedge clk);
            out_ready = !(cyc >= 4 && cyc < 7);
            if (sent < 8) begin
                for (int l = 0; l < NL; l++) d[l*FW +: FW] = FW'((sent*4 + l - 10) * 256);
                in_valid = 1'b1;
                in_data  = d;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (stalled) begin
                check("stall_hold_valid", out_valid, 1);
                check("stall_hold_data", out_data, held);
            end
            if (out_valid && !out_ready) begin
                check("stall_in_ready", in_ready, 0);
                held    = out_data;
                stalled = 1'b1;
            end else begin
                stalled = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("stream_extra_beat", 1, 0);
                else begin
                    check("stream_data", out_data, exp_q.pop_front());
                    got++;
                end
            end
            if (in_valid && in_ready) begin
                for (int l = 0; l < NL; l++) e[l*W +: W] = W'(sent*4 + l - 10);
                exp_q.push_back(e);
                sent++;
            end
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_count", got, 8);
        check("stream_q_empty", exp_q.size(), 0);
    endtask

    initial begin
        vecs[0] = mk(2'd0, 98304, 128, 384, -128, 12'h180, 12'h000, 12'h001, 12'hFFF, 4'b0000);
        vecs[1] = mk(2'd1, 98304, 128, 384, -128, 12'h180, 12'h001, 12'h002, 12'h000, 4'b0000);
        vecs[2] = mk(2'd2, 98304, 128, 384, -128, 12'h180, 12'h000, 12'h002, 12'h000, 4'b0000);
        vecs[3] = mk(2'd0, 655360, -655360, 524160, -524288,
                     12'h7FF, 12'h800, 12'h7FF, 12'h800, 4'b0011);
        vecs[4] = mk(2'd1, 524160, 32'h1000000, 200, 32'h2000000,
                     12'h7FF, 12'h7FF, 12'h001, 12'h7FF, 4'b1011);
        vecs[5] = mk(2'd2, 200, 640, 896, -384, 12'h001, 12'h002, 12'h004, 12'hFFE, 4'b0000);
        vecs[6] = mk(2'd3, 98304, 384, -128, 255, 12'h180, 12'h001, 12'hFFF, 12'h000, 4'b0000);
        vecs[7] = mk(2'd1, -129, 127, 383, -1, 12'hFFF, 12'h000, 12'h001, 12'h000, 4'b0000);

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_sat_count", sat_count, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);

        for (int i = 0; i < 8; i++) run_vec(i);
        check("sat_count_after_vecs", sat_count, 5);

        stall_stream();
        repeat (3) @(negedge clk);
        check("sat_count_after_stream", sat_count, 5);

        // Clear coincident with a fully saturated beat drops its popcount
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = all_lanes(655360);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("clr_beat_valid", out_valid, 1);
        check("clr_beat_sat", out_sat, 4'hF);
        sat_clr = 1'b1;
        @(negedge clk);
        sat_clr = 1'b0;
        check("clr_coincident", sat_count, 0);

        // Counter clamp
        stream_beats(16383, all_lanes(655360));
        check("cnt_near_max", sat_count, 16'hFFFC);
        stream_beats(1, all_lanes(655360));
        check("cnt_clamp", sat_count, 16'hFFFF);
        stream_beats(1, {FW'(0), FW'(0), FW'(0), FW'(32'h1000000)});
        check("cnt_stick", sat_count, 16'hFFFF);

        // Asynchronous reset mid-stream
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = all_lanes(-655360);
        repeat (3) @(negedge clk);
        check("arst_pre_valid", out_valid, 1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_sat_count", sat_count, 0);
        check("arst_out_data", out_data, 0);
        check("arst_out_sat", out_sat, 0);
        in_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("arst_after_valid", out_valid, 0);
        check("arst_after_ready", in_ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fxp_lane_converter.md
Name: fxp_lane_converter

Overview:
- Pipelined, multi-lane fixed-point format converter for the DNN datapath.
- Converts NUM_LANES signed values from {from_sign_bits, from_int_bits, from_frac_bits} to {sign_bits, int_bits, frac_bits}.
- Handles both narrowing (rounding plus saturation) and widening (sign-extend plus zero-pad); the mode follows from the parameters.
- Adds a selectable rounding mode, a valid/ready handshake, per-lane saturation flags and a sticky saturation counter.
- Sits between accumulator outputs and activation/weight-update stages.

Parameters:
- NUM_LANES, 4, number of independent lanes converted per beat.
- from_width, 26, input word width.
- from_sign_bits, 2, redundant sign bits of input.
- from_int_bits, 8, input integer bits; from_frac_bits = from_width-from_sign_bits-from_int_bits (localparam).
- width, 12, output word width.
- sign_bits, 1, output sign bits.
- int_bits, 3, output integer bits; frac_bits = width-sign_bits-int_bits (localparam).
- SAT_CNT_W, 16, saturation counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- round_mode  in  2  0 = truncate (floor), 1 = round-half-up, 2 = round-half-even, 3 = reserved (treated as 0). Sampled with in_valid&&in_ready.
- in_valid  in  1  input beat valid.
- in_ready  out  1  converter can accept a beat.
- in_data  in  NUM_LANES*from_width  lane i at [i*from_width +: from_width], signed.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  NUM_LANES*width  lane i at [i*width +: width], signed.
- out_sat  out  NUM_LANES  per-lane flag: lane saturated or hit the sign-bit exception.
- sat_clr  in  1  synchronous clear of sat_count.
- sat_count  out  SAT_CNT_W  count of saturated lanes delivered; sticks at all-ones.

Behaviour:
- Reset (reset_n=0, async): both stage valids = 0, out_valid=0, out_data=0, out_sat=0, sat_count=0. in_ready=1 once reset is released.
- Two register stages.
  - S1: rounding and saturation, registered.
  - S2: output register.
- Global enable en = !out_valid || out_ready.
  - in_ready = en.
  - S1 and S2 advance only when en=1; no bubble collapsing.
- Latency: a beat accepted at cycle t appears on out_valid at t+2 when out_ready stays high.
- Throughput: 1 beat/cycle.
- Stall: while out_valid && !out_ready, out_data, out_sat and out_valid hold stable; S1 holds.
- Narrowing arithmetic, per lane (D = from_frac_bits - frac_bits > 0):
  - Exception: if the from_sign_bits MSBs are not all equal, result = max positive {sign_bits 0s, 1s}, sat = 1.
  - Otherwise, with x = in >>> D (floor), g = bit D-1, s = OR of bits D-2..0:
    - truncate: r = x.
    - half-up: r = x + g.
    - half-even: r = x + (g && (s || x[0])).
  - r is computed at full precision plus 1 bit.
  - Saturation is applied after rounding:
    - r > 2^(int_bits+frac_bits)-1 → max positive, sat = 1.
    - r < -2^(int_bits+frac_bits) → max negative {sign_bits 1s, 0s}, sat = 1.
    - Otherwise r is sign-extended to width.
  - Rounding never wraps.
- Widening (frac_bits >= from_frac_bits and int_bits >= from_int_bits):
  - Output = sign-extend(in) followed by (frac_bits - from_frac_bits) zeros.
  - sat = 0 unless the sign-bit exception fires; the exception then gives max positive, sat = 1.
  - round_mode is ignored.
- Mixed (frac narrows, int widens, or the reverse): apply each rule independently. Elaboration must not fail for any legal combination.
- sat_count:
  - On each out_valid && out_ready, add popcount(out_sat).
  - Clamp at 2^SAT_CNT_W - 1.
  - sat_clr has priority: if sat_clr=1, sat_count becomes 0 that cycle and the coincident beat's popcount is discarded.
- Lanes are fully independent; out_sat bit i belongs to lane i.

Test Plan (defaults: in Q2.8.16, out Q1.3.8):
- Lane0 = 98304 (1.5), all modes, out_ready=1 → lane0 out 12'h180 exactly 2 cycles after acceptance, out_sat[0]=0.
- Input 128 / 384 / -128 (0.5 / 1.5 / -0.5 output LSB):
  - truncate → 0 / 1 / 12'hFFF.
  - half-up → 1 / 2 / 0.
  - half-even → 0 / 2 / 0.
- Input 655360 (10.0) → 12'h7FF, sat=1. Input -655360 → 12'h800, sat=1. Input 524160 with half-up → 12'h7FF (no wrap), sat=1.
- Input 26'h1000000 (sign bits differ) → 12'h7FF, out_sat=1; sat_count increments by 1 per such lane.
- Stream 8 beats; hold out_ready=0 for 3 cycles mid-stream → in_ready=0 during the stall, no beat lost or duplicated, output order preserved.
- Sat counter:
  - Preset sat_count near all-ones → clamps at 16'hFFFF.
  - sat_clr coincident with a 4-lane saturated beat → 0.
  - Assert reset_n low mid-stream → out_valid=0 and sat_count=0 immediately (async).
